// File: rtl/trigger_stats_pkg.sv
// trigger_stats_pkg: shared widths, saturation constants and FSM state type for trigger_stream_stats
package trigger_stats_pkg;
    localparam int SAMPLE_BITS   = 5;
    localparam int NSAMP         = 8;
    localparam int SQ_BITS       = 9;
    localparam int LANE_SQ_BITS  = 12;
    localparam int LANE_SUM_BITS = 8;
    localparam int LANE_SAT_BITS = 4;
    localparam logic signed [SAMPLE_BITS-1:0] SAT_HI = 5'sb01111;
    localparam logic signed [SAMPLE_BITS-1:0] SAT_LO = 5'sb10000;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
endpackage

// File: rtl/trigger_stats_lane_tree.sv
// trigger_stats_lane_tree: 2-stage per-clock reduction of 8 x 5-bit samples to lane sum, sum of squares, saturation count
// Ports: aclk, aresetn (async active-low), dat_i[39:0] in; sum_o (signed 8), sumsq_o (12), sat_o (4, only with TRIGGER_STATS_SAT_EN) out.
// Stage 1 registers squares, sign-extended samples and saturation flags; stage 2 registers the adder-tree results.
module trigger_stats_lane_tree
    import trigger_stats_pkg::*;
(
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [NSAMP*SAMPLE_BITS-1:0]    dat_i,
`ifdef TRIGGER_STATS_SAT_EN
    output logic [LANE_SAT_BITS-1:0]        sat_o,
`endif
    output logic signed [LANE_SUM_BITS-1:0] sum_o,
    output logic [LANE_SQ_BITS-1:0]         sumsq_o
);
    logic signed [SQ_BITS-1:0]       ext  [NSAMP];
    logic [SQ_BITS-1:0]              sq_r [NSAMP];
    logic signed [LANE_SUM_BITS-1:0] sx_r [NSAMP];
    logic signed [LANE_SUM_BITS-1:0] sum_c;
    logic [LANE_SQ_BITS-1:0]         sq_c;

    // 9-bit signed operands keep (-16)^2 = 256 representable in the 9-bit product
    always_comb
        for (int i = 0; i < NSAMP; i++)
            ext[i] = SQ_BITS'($signed(dat_i[SAMPLE_BITS*i +: SAMPLE_BITS]));

    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn)
            for (int i = 0; i < NSAMP; i++) begin
                sq_r[i] <= '0;
                sx_r[i] <= '0;
            end
        else
            for (int i = 0; i < NSAMP; i++) begin
                sq_r[i] <= ext[i] * ext[i];
                sx_r[i] <= ext[i][LANE_SUM_BITS-1:0];
            end

    always_comb begin
        sum_c = '0;
        sq_c  = '0;
        for (int i = 0; i < NSAMP; i++) begin
            sum_c = sum_c + sx_r[i];
            sq_c  = sq_c + LANE_SQ_BITS'(sq_r[i]);
        end
    end

    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            sum_o   <= '0;
            sumsq_o <= '0;
        end else begin
            sum_o   <= sum_c;
            sumsq_o <= sq_c;
        end

`ifdef TRIGGER_STATS_SAT_EN
    logic [NSAMP-1:0] sat_r;

    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            sat_r <= '0;
            sat_o <= '0;
        end else begin
            for (int i = 0; i < NSAMP; i++)
                sat_r[i] <= $signed(dat_i[SAMPLE_BITS*i +: SAMPLE_BITS]) == SAT_HI ||
                            $signed(dat_i[SAMPLE_BITS*i +: SAMPLE_BITS]) == SAT_LO;
            sat_o <= LANE_SAT_BITS'($countones(sat_r));
        end
`endif
endmodule

// File: rtl/trigger_stream_stats.sv
// trigger_stream_stats: windowed sum / sum-of-squares / saturation-count engine for the 40-bit AGC sample stream
// Ports: aclk, aresetn (async active-low), dat_i[39:0], start_i, ack_i in;
//        busy_o, valid_o, sum_o (signed 8+W), sumsq_o (12+W), sat_o (4+W) out; W = WINDOW_LOG2.
// Build option: define TRIGGER_STATS_SAT_EN to build the saturation counter; otherwise sat_o is tied to 0.
module trigger_stream_stats
    import trigger_stats_pkg::*;
#(
    parameter int WINDOW_LOG2 = 16
)
(
    input  logic                                        aclk,
    input  logic                                        aresetn,
    input  logic [NSAMP*SAMPLE_BITS-1:0]                dat_i,
    input  logic                                        start_i,
    input  logic                                        ack_i,
    output logic                                        busy_o,
    output logic                                        valid_o,
    output logic signed [LANE_SUM_BITS+WINDOW_LOG2-1:0] sum_o,
    output logic [LANE_SQ_BITS+WINDOW_LOG2-1:0]         sumsq_o,
    output logic [LANE_SAT_BITS+WINDOW_LOG2-1:0]        sat_o
);
    state_t                          state;
    logic [WINDOW_LOG2-1:0]          cnt;
    logic [1:0]                      fcnt;
    logic                            v1, v2;
    logic                            accept;
    logic signed [LANE_SUM_BITS-1:0] lane_sum;
    logic [LANE_SQ_BITS-1:0]         lane_sq;

    assign accept = state == IDLE && start_i;

`ifdef TRIGGER_STATS_SAT_EN
    logic [LANE_SAT_BITS-1:0] lane_sat;
`endif

    trigger_stats_lane_tree u_tree (
        .aclk    (aclk),
        .aresetn (aresetn),
        .dat_i   (dat_i),
`ifdef TRIGGER_STATS_SAT_EN
        .sat_o   (lane_sat),
`endif
        .sum_o   (lane_sum),
        .sumsq_o (lane_sq)
    );

    // v1/v2 track which lane-tree outputs belong to the window; the final
    // accumulator update lands two edges into FLUSH, and DONE follows so that
    // valid_o rises 2^WINDOW_LOG2 + 4 edges after start_i is accepted
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            state   <= IDLE;
            cnt     <= '0;
            fcnt    <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            v1 <= state == RUN;
            v2 <= v1;
            case (state)
                IDLE:
                    if (start_i) begin
                        state  <= RUN;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                    end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state <= FLUSH;
                        fcnt  <= '0;
                    end
                end
                FLUSH: begin
                    fcnt <= fcnt + 1'b1;
                    if (&fcnt) begin
                        state   <= DONE;
                        busy_o  <= 1'b0;
                        valid_o <= 1'b1;
                    end
                end
                DONE:
                    if (ack_i) begin
                        state   <= IDLE;
                        valid_o <= 1'b0;
                    end
                default: state <= IDLE;
            endcase
        end

    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            sum_o   <= '0;
            sumsq_o <= '0;
        end else if (accept) begin
            sum_o   <= '0;
            sumsq_o <= '0;
        end else if (v2) begin
            sum_o   <= sum_o + {{WINDOW_LOG2{lane_sum[LANE_SUM_BITS-1]}}, lane_sum};
            sumsq_o <= sumsq_o + {{WINDOW_LOG2{1'b0}}, lane_sq};
        end

`ifdef TRIGGER_STATS_SAT_EN
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn)
            sat_o <= '0;
        else if (accept)
            sat_o <= '0;
        else if (v2)
            sat_o <= sat_o + {{WINDOW_LOG2{1'b0}}, lane_sat};
`else
    assign sat_o = '0;
`endif
endmodule

// File: tb/tb_trigger_stream_stats.sv
// tb_trigger_stream_stats: scoreboard bench for trigger_stream_stats with WINDOW_LOG2=2
module tb_trigger_stream_stats;
    localparam int W = 2;
`ifdef TRIGGER_STATS_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        longint sum;
        longint sq;
        longint sat;
        longint cyc;
    } exp_t;

    logic                   aclk = 1'b0;
    logic                   aresetn = 1'b0;
    logic [39:0]            dat = '0;
    logic                   start = 1'b0;
    logic                   ack = 1'b0;
    logic                   busy_o, valid_o;
    logic signed [7+W:0]    sum_o;
    logic [11+W:0]          sumsq_o;
    logic [3+W:0]           sat_o;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    int     pushes = 0;
    int     pops = 0;
    longint cyc = 0;
    bit     done = 1'b0;

    trigger_stream_stats #(.WINDOW_LOG2(W)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .dat_i   (dat),
        .start_i (start),
        .ack_i   (ack),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .sum_o   (sum_o),
        .sumsq_o (sumsq_o),
        .sat_o   (sat_o)
    );

    always #5 aclk = ~aclk;

    initial forever begin
        @(posedge aclk);
        cyc = cyc + 1;
    end

    task automatic chk(input string n, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    function automatic logic [39:0] rep(input logic [4:0] a, input logic [4:0] b);
        logic [39:0] r;
        for (int i = 0; i < 8; i++)
            r[5*i +: 5] = (i % 2 == 1) ? b : a;
        return r;
    endfunction

    // monitor: compare every rising valid_o against the oldest expectation
    initial begin
        exp_t e;
        logic vprev = 1'b0;
        forever begin
            @(negedge aclk);
            if (valid_o && !vprev) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid_o=1 expected no result pending");
                end else begin
                    e = q.pop_front();
                    pops++;
                    chk("sum", longint'(sum_o), e.sum);
                    chk("sumsq", longint'(sumsq_o), e.sq);
                    chk("sat", longint'(sat_o), e.sat);
                    chk("latency", cyc - e.cyc, 2**W + 4);
                end
            end
            vprev = valid_o;
        end
    end

    // caller is at a negedge; start is accepted on the next posedge
    task automatic start_window(input logic [39:0] d, input longint s, input longint sq,
                                input longint st, input bit push);
        dat   = d;
        start = 1'b1;
        if (push) begin
            q.push_back('{s, sq, SAT ? st : 0, cyc + 1});
            pushes++;
        end
        @(negedge aclk);
        start = 1'b0;
        chk("busy_run", longint'(busy_o), 1);
        chk("valid_run", longint'(valid_o), 0);
    endtask

    task automatic wait_valid(input string n);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge aclk);
            if (valid_o) break;
        end
        if (k == 40) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got valid_o=0 expected 1 within 40 cycles", n);
        end
    endtask

    task automatic finish_window(input string n);
        wait_valid(n);
        ack = 1'b1;
        @(negedge aclk);
        ack = 1'b0;
        chk("valid_after_ack", longint'(valid_o), 0);
    endtask

    initial begin
        repeat (3) @(negedge aclk);
        chk("rst_busy", longint'(busy_o), 0);
        chk("rst_valid", longint'(valid_o), 0);
        chk("rst_sum", longint'(sum_o), 0);
        chk("rst_sumsq", longint'(sumsq_o), 0);
        chk("rst_sat", longint'(sat_o), 0);
        aresetn = 1'b1;
        @(negedge aclk);

        start_window(rep(5'd1, 5'd1), 32, 32, 0, 1'b1);
        finish_window("ones");
        start_window(rep(5'b10000, 5'b10000), -512, 8192, 32, 1'b1);
        finish_window("neg16");
        start_window(rep(5'b01111, 5'b10001), 0, 7200, 16, 1'b1);
        finish_window("alt15");

        // start pulses in RUN and DONE are ignored; ack+start in DONE returns to IDLE only
        start_window(rep(5'd1, 5'd1), 32, 32, 0, 1'b1);
        @(negedge aclk);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        wait_valid("ignore");
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        chk("done_start_valid", longint'(valid_o), 1);
        chk("done_start_busy", longint'(busy_o), 0);
        ack   = 1'b1;
        start = 1'b1;
        @(negedge aclk);
        ack   = 1'b0;
        start = 1'b0;
        chk("ack_start_valid", longint'(valid_o), 0);
        repeat (4) @(negedge aclk);
        chk("no_window_busy", longint'(busy_o), 0);
        chk("no_window_valid", longint'(valid_o), 0);

        // reset during the second RUN cycle discards the window
        start_window(rep(5'd3, 5'd3), 0, 0, 0, 1'b0);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("midrst_busy", longint'(busy_o), 0);
        chk("midrst_valid", longint'(valid_o), 0);
        chk("midrst_sum", longint'(sum_o), 0);
        chk("midrst_sumsq", longint'(sumsq_o), 0);
        chk("midrst_sat", longint'(sat_o), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (8) @(negedge aclk);
        chk("postrst_busy", longint'(busy_o), 0);
        chk("postrst_valid", longint'(valid_o), 0);
        start_window(rep(5'd1, 5'd1), 32, 32, 0, 1'b1);
        finish_window("postrst");

        // back-to-back windows at minimum ack->start spacing
        start_window(rep(5'd1, 5'd1), 32, 32, 0, 1'b1);
        finish_window("b2b_first");
        chk("hold_sum", longint'(sum_o), 32);
        chk("hold_sumsq", longint'(sumsq_o), 32);
        start_window(rep(5'd2, 5'd2), 64, 128, 0, 1'b1);
        chk("clear_sum", longint'(sum_o), 0);
        finish_window("b2b_second");

        repeat (3) @(negedge aclk);
        chk("scoreboard_pops", pops, pushes);
        chk("queue_empty", q.size(), 0);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: got no completion expected finish before 100000 time units");
            $fatal(1, "watchdog");
        end
    end
endmodule
